// File: rtl/lutram_fifo_sync.sv
// rtl/lutram_fifo_sync.sv - synchronous valid/ready FIFO on distributed RAM, first-word-fall-through
// Write is synchronous, read is asynchronous so the head word is always presented on RD_DAT.

module lutram_fifo_sync #(
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              CLEAR,
  input  logic              WR_VLD,
  output logic              WR_RDY,
  input  logic [WIDTH-1:0]  WR_DAT,
  output logic              RD_VLD,
  input  logic              RD_RDY,
  output logic [WIDTH-1:0]  RD_DAT,
  output logic [ADDR_W:0]   LEVEL
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign WR_RDY = !full;
  assign RD_VLD = !empty;

  assign push = WR_VLD && !full;
  assign pop  = RD_RDY && !empty;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset so it maps onto LUT RAM.
  always_ff @(posedge CLK) begin
    if (push && !CLEAR) mem[wr_ptr[ADDR_W-1:0]] <= WR_DAT;
  end

  assign RD_DAT = mem[rd_ptr[ADDR_W-1:0]];
  assign LEVEL  = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_lutram_fifo_sync.sv
// tb/tb_lutram_fifo_sync.sv - self-checking bench for lutram_fifo_sync with a queue scoreboard
// Each cycle compares flags, level and head data against a reference queue.

module tb_lutram_fifo_sync;

  localparam int WIDTH  = 2;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RESETN;
  logic              CLEAR;
  logic              WR_VLD;
  logic              WR_RDY;
  logic [WIDTH-1:0]  WR_DAT;
  logic              RD_VLD;
  logic              RD_RDY;
  logic [WIDTH-1:0]  RD_DAT;
  logic [ADDR_W:0]   LEVEL;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] sb[$];

  lutram_fifo_sync #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .CLEAR  (CLEAR),
    .WR_VLD (WR_VLD),
    .WR_RDY (WR_RDY),
    .WR_DAT (WR_DAT),
    .RD_VLD (RD_VLD),
    .RD_RDY (RD_RDY),
    .RD_DAT (RD_DAT),
    .LEVEL  (LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; drives inputs, checks outputs, advances one clock.
  task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic clr);
    bit can_push;
    bit can_pop;
    logic [WIDTH-1:0] head;
    WR_VLD = wv;
    WR_DAT = wd;
    RD_RDY = rr;
    CLEAR  = clr;
    #1;
    can_push = (sb.size() < DEPTH);
    can_pop  = (sb.size() > 0);
    check("wr_rdy", 32'(WR_RDY), 32'(can_push));
    check("rd_vld", 32'(RD_VLD), 32'(can_pop));
    check("level",  32'(LEVEL),  32'(sb.size()));
    if (can_pop) check("rd_dat", 32'(RD_DAT), 32'(sb[0]));
    @(posedge CLK);
    if (clr) begin
      sb.delete();
    end else begin
      if (rr && can_pop) head = sb.pop_front();
      if (wv && can_push) sb.push_back(wd);
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    RESETN = 1'b0;
    CLEAR  = 1'b0;
    WR_VLD = 1'b0;
    WR_DAT = '0;
    RD_RDY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_rd_vld", 32'(RD_VLD), 32'd0);
    check("reset_wr_rdy", 32'(WR_RDY), 32'd1);
    check("reset_level",  32'(LEVEL),  32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    repeat (3) idle();

    // Asynchronous reset in the middle of a cycle with data stored
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
    WR_VLD = 1'b0;
    #2;
    RESETN = 1'b0;
    #1;
    check("async_rst_rd_vld", 32'(RD_VLD), 32'd0);
    check("async_rst_wr_rdy", 32'(WR_RDY), 32'd1);
    check("async_rst_level",  32'(LEVEL),  32'd0);
    sb.delete();
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    idle();

    // Fill to full; the 17th offer must be refused
    for (int i = 0; i < 17; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    #1;
    check("full_level",  32'(LEVEL),  32'd16);
    check("full_wr_rdy", 32'(WR_RDY), 32'd0);

    // Drain everything; data order 0,1,2,3,0,...
    for (int i = 0; i < 16; i++) begin
      #1;
      check("drain_seq", 32'(RD_DAT), 32'(i % 4));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("drained_rd_vld", 32'(RD_VLD), 32'd0);
    check("drained_level",  32'(LEVEL),  32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Steady state at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(3 - i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
    check("steady_level", 32'(LEVEL), 32'd5);

    // Full with push and pop in the same cycle: pop only
    while (sb.size() < DEPTH) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b1, 1'b0);
    check("full_pp_level",  32'(LEVEL),  32'd15);
    check("full_pp_wr_rdy", 32'(WR_RDY), 32'd1);

    // Empty push: visible the next cycle
    while (sb.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 2'd2, 1'b1, 1'b0);
    check("empty_push_rd_vld", 32'(RD_VLD), 32'd1);
    check("empty_push_rd_dat", 32'(RD_DAT), 32'd2);
    idle();

    // CLEAR at level 9 with push and pop requested
    while (sb.size() < 9) cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 1'b1, 1'b1);
    check("clear_level",  32'(LEVEL),  32'd0);
    check("clear_rd_vld", 32'(RD_VLD), 32'd0);
    check("clear_wr_rdy", 32'(WR_RDY), 32'd1);
    idle();

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0 ? ($urandom & 1) : 1),
            1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
